// File: rtl/captcha_circles_multi.sv
// Multi-round circle-click CAPTCHA: LFSR-placed circles, parallel hit testing,
// per-round timeout, wrong-click budget and registered RGB565 pixel rendering.
module captcha_circles_multi #(
  parameter int unsigned NUM_CIRCLES    = 4,
  parameter int unsigned ROUNDS         = 3,
  parameter int unsigned R_MIN          = 4,
  parameter int unsigned R_MAX          = 14,
  parameter int unsigned MAX_FAILS      = 2,
  parameter int unsigned TIMEOUT_CYCLES = 500000000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        en,
  input  logic [15:0] seed,
  input  logic        left,
  input  logic [6:0]  xpos,
  input  logic [5:0]  ypos,
  input  logic [6:0]  x,
  input  logic [5:0]  y,
  output logic        pass,
  output logic        fail,
  output logic        busy,
  output logic [2:0]  round_idx,
  output logic [15:0] pixel_data
);

  typedef enum logic [2:0] {S_IDLE, S_GEN, S_WAIT, S_CHECK, S_DONE} state_t;

  localparam int unsigned R_SPAN       = R_MAX - R_MIN + 1;
  localparam logic [15:0] LFSR_DEFAULT = 16'hACE1;

  state_t      state;
  logic [15:0] lfsr;
  logic [6:0]  cx_mem [NUM_CIRCLES];
  logic [5:0]  cy_mem [NUM_CIRCLES];
  logic [4:0]  r_mem  [NUM_CIRCLES];
  logic [2:0]  k;
  logic [2:0]  target;
  logic [6:0]  rej_cnt;
  logic [31:0] timer;
  logic [7:0]  fail_cnt;
  logic        left_q;
  logic [6:0]  click_x;
  logic [5:0]  click_y;

  logic [4:0]  cand_r;
  logic [6:0]  cand_cx;
  logic [5:0]  cand_cy;
  logic        cand_ok;
  logic        force_place;
  logic        lfsr_fb;
  logic        rise;
  logic        hit_tgt;
  logic        hit_other;
  logic [6:0]  adx;
  logic [5:0]  ady;
  logic        on_cursor;
  logic        tgt_px;
  logic        ring_px;
  logic        draw;
  logic [15:0] pix_next;

  function automatic logic [14:0] dist2(input logic [6:0] ax, input logic [5:0] ay,
                                        input logic [6:0] bx, input logic [5:0] by);
    logic signed [15:0] dx;
    logic signed [15:0] dy;
    logic signed [15:0] sum;
    dx  = $signed({9'b0, ax}) - $signed({9'b0, bx});
    dy  = $signed({10'b0, ay}) - $signed({10'b0, by});
    sum = dx * dx + dy * dy;
    return sum[14:0];
  endfunction

  function automatic logic [9:0] rsq(input logic [4:0] r);
    return {5'b0, r} * {5'b0, r};
  endfunction

  // |d2 - r*r| <= r, rearranged to stay in unsigned arithmetic
  function automatic logic in_ring(input logic [14:0] d2, input logic [4:0] r);
    return ({1'b0, d2} + {11'b0, r} >= {6'b0, rsq(r)}) &&
           ({1'b0, d2} <= {6'b0, rsq(r)} + {11'b0, r});
  endfunction

  assign lfsr_fb     = lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10];
  assign rise        = left & ~left_q;
  assign force_place = (rej_cnt == 7'd64);

  always_comb begin
    cand_r  = 5'(R_MIN + 32'(lfsr[4:0]) % R_SPAN);
    cand_cx = lfsr[11:5];
    cand_cy = lfsr[15:10];
    cand_ok = ({2'b0, cand_r} <= cand_cx) && (cand_cx <= 7'd95 - {2'b0, cand_r}) &&
              ({1'b0, cand_r} <= cand_cy) && (cand_cy <= 6'd63 - {1'b0, cand_r});
  end

  always_comb begin
    hit_tgt   = 1'b0;
    hit_other = 1'b0;
    for (int unsigned i = 0; i < NUM_CIRCLES; i++) begin
      if (dist2(cx_mem[i], cy_mem[i], click_x, click_y) <= {5'b0, rsq(r_mem[i])}) begin
        if (3'(i) == target) hit_tgt = 1'b1;
        else                 hit_other = 1'b1;
      end
    end
  end

  always_comb begin
    adx       = (x >= xpos) ? x - xpos : xpos - x;
    ady       = (y >= ypos) ? y - ypos : ypos - y;
    on_cursor = ((x == xpos) && (ady <= 6'd1)) || ((y == ypos) && (adx <= 7'd1));
    tgt_px    = 1'b0;
    ring_px   = 1'b0;
    for (int unsigned i = 0; i < NUM_CIRCLES; i++) begin
      if (3'(i) == target) begin
        if (dist2(cx_mem[i], cy_mem[i], x, y) <= {5'b0, rsq(r_mem[i])}) tgt_px = 1'b1;
      end else if (in_ring(dist2(cx_mem[i], cy_mem[i], x, y), r_mem[i])) begin
        ring_px = 1'b1;
      end
    end
    draw = state inside {S_WAIT, S_CHECK, S_DONE};
    if (!en || state == S_IDLE) pix_next = '0;
    else if (on_cursor)         pix_next = 16'h07E0;
    else if (draw && tgt_px)    pix_next = 16'hF800;
    else if (draw && ring_px)   pix_next = 16'hFFFF;
    else                        pix_next = '0;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) pixel_data <= '0;
    else       pixel_data <= pix_next;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= S_IDLE;
      lfsr      <= LFSR_DEFAULT;
      k         <= '0;
      target    <= '0;
      rej_cnt   <= '0;
      timer     <= '0;
      fail_cnt  <= '0;
      left_q    <= 1'b0;
      click_x   <= '0;
      click_y   <= '0;
      pass      <= 1'b0;
      fail      <= 1'b0;
      busy      <= 1'b0;
      round_idx <= '0;
      for (int unsigned i = 0; i < NUM_CIRCLES; i++) begin
        cx_mem[i] <= '0;
        cy_mem[i] <= '0;
        r_mem[i]  <= '0;
      end
    end else begin
      left_q <= left;
      pass   <= 1'b0;
      fail   <= 1'b0;
      if (!en) begin
        state     <= S_IDLE;
        busy      <= 1'b0;
        round_idx <= '0;
        fail_cnt  <= '0;
        timer     <= '0;
        k         <= '0;
        rej_cnt   <= '0;
      end else begin
        case (state)
          S_IDLE: begin
            state     <= S_GEN;
            lfsr      <= (seed == 16'h0000) ? LFSR_DEFAULT : seed;
            k         <= '0;
            rej_cnt   <= '0;
            busy      <= 1'b1;
            round_idx <= '0;
            fail_cnt  <= '0;
            timer     <= '0;
          end
          S_GEN: begin
            lfsr <= {lfsr[14:0], lfsr_fb};
            if (force_place || cand_ok) begin
              for (int unsigned i = 0; i < NUM_CIRCLES; i++) begin
                if (3'(i) == k) begin
                  cx_mem[i] <= force_place ? 7'd48 : cand_cx;
                  cy_mem[i] <= force_place ? 6'd32 : cand_cy;
                  r_mem[i]  <= force_place ? 5'(R_MIN) : cand_r;
                end
              end
              rej_cnt <= '0;
              if (k == 3'(NUM_CIRCLES - 1)) begin
                target <= 3'(32'(lfsr[2:0]) % NUM_CIRCLES);
                timer  <= '0;
                state  <= S_WAIT;
              end else begin
                k <= k + 3'd1;
              end
            end else begin
              rej_cnt <= rej_cnt + 7'd1;
            end
          end
          // Expiry is checked before the click so a simultaneous edge loses
          S_WAIT: begin
            if ((TIMEOUT_CYCLES != 0) && (timer == TIMEOUT_CYCLES - 1)) begin
              fail  <= 1'b1;
              busy  <= 1'b0;
              state <= S_DONE;
            end else begin
              timer <= timer + 32'd1;
              if (rise) begin
                click_x <= xpos;
                click_y <= ypos;
                state   <= S_CHECK;
              end
            end
          end
          S_CHECK: begin
            if (hit_tgt) begin
              round_idx <= round_idx + 3'd1;
              if (round_idx == 3'(ROUNDS - 1)) begin
                pass  <= 1'b1;
                busy  <= 1'b0;
                state <= S_DONE;
              end else begin
                k       <= '0;
                rej_cnt <= '0;
                state   <= S_GEN;
              end
            end else if (hit_other) begin
              fail_cnt <= fail_cnt + 8'd1;
              if (32'(fail_cnt) + 32'd1 >= MAX_FAILS) begin
                fail  <= 1'b1;
                busy  <= 1'b0;
                state <= S_DONE;
              end else begin
                state <= S_WAIT;
              end
            end else begin
              state <= S_WAIT;
            end
          end
          S_DONE: state <= S_DONE;
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule
